// File: rtl/fft_pkg.sv
// Shared constants, loader FSM state type and index bit-reversal helper for the FFT frame loader.
package fft_pkg;

   localparam int DATA_W = 32;
   localparam int LOG2N  = 4;
   localparam int N      = 1 << LOG2N;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      DRAIN = 2'd1,
      SWAP  = 2'd2
   } state_t;

   // Reverses the low w bits of i; bits at and above w come back as zero.
   function automatic logic [15:0] bitrev(input logic [15:0] i, input int w);
      logic [15:0] r;
      r = '0;
      for (int b = 0; b < 16; b++) begin
         if (b < w) r[b] = i[4'(w - 1 - b)];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational frame-index remapper: bit-reversed when BITREV_EN is defined, natural order otherwise.
module fft_bitrev_addr #(
   parameter int W = fft_pkg::LOG2N
) (
   input  logic [W-1:0] idx,
   output logic [W-1:0] addr
);

`ifdef BITREV_EN
   assign addr = W'(fft_pkg::bitrev(16'(idx), W));
`else
   assign addr = idx;
`endif

endmodule

// File: rtl/fft_frame_loader.sv
// Drains the sample FIFO into a ping-pong frame memory for the FFT core.
// Optional BITREV_EN build macro stores each frame in bit-reversed index order.
//
//   state | meaning
//   FILL  | issuing FIFO reads / memory writes into wr_bank (stalls while that bank is full)
//   DRAIN | all N reads issued, waiting for the last in-flight write
//   SWAP  | one cycle: mark wr_bank full, move to the other bank, clear counters
module fft_frame_loader #(
   parameter int DATA_W = fft_pkg::DATA_W,
   parameter int LOG2N  = fft_pkg::LOG2N
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              EN,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              fifo_empty,
   output logic              fifo_rd,
   output logic              mem_we,
   output logic [LOG2N:0]    mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              frame_ready,
   output logic              frame_bank,
   input  logic              frame_ack
);

   import fft_pkg::state_t;
   import fft_pkg::FILL;
   import fft_pkg::DRAIN;
   import fft_pkg::SWAP;

   localparam int             N_PTS = 1 << LOG2N;
   localparam logic [LOG2N:0] N_CNT = N_PTS[LOG2N:0];
   localparam logic [LOG2N:0] ONE   = (LOG2N+1)'(1);

   state_t           state, state_nxt;
   logic [LOG2N:0]   rd_cnt, wr_cnt;
   logic             wr_bank;
   logic [1:0]       bank_full, bank_full_nxt;
   logic             rd_q;
   logic             ack_ok;
   logic [LOG2N-1:0] wr_idx_map;

   fft_bitrev_addr #(.W(LOG2N)) u_bitrev_addr (
      .idx  (wr_cnt[LOG2N-1:0]),
      .addr (wr_idx_map)
   );

   assign fifo_rd = (state == FILL) && EN && !fifo_empty && !bank_full[wr_bank] && (rd_cnt < N_CNT);

   // frame_bank always names the oldest full bank, so an ack frees exactly that one.
   assign ack_ok = frame_ack && frame_ready;

   always_comb begin
      state_nxt     = state;
      bank_full_nxt = bank_full;
      case (state)
         FILL:    if (rd_cnt == N_CNT) state_nxt = DRAIN;
         DRAIN:   if (wr_cnt == N_CNT) state_nxt = SWAP;
         SWAP:    state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
      if (ack_ok)         bank_full_nxt[frame_bank] = 1'b0;
      if (state == SWAP)  bank_full_nxt[wr_bank]    = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= FILL;
         rd_cnt      <= '0;
         wr_cnt      <= '0;
         wr_bank     <= 1'b0;
         bank_full   <= '0;
         rd_q        <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_data    <= '0;
         frame_ready <= 1'b0;
         frame_bank  <= 1'b0;
      end else begin
         state       <= state_nxt;
         bank_full   <= bank_full_nxt;
         frame_ready <= |bank_full_nxt;
         rd_q        <= fifo_rd;
         mem_we      <= rd_q;
         if (ack_ok)  frame_bank <= ~frame_bank;
         if (fifo_rd) rd_cnt <= rd_cnt + ONE;
         // FIFO data for a read issued last cycle is valid now.
         if (rd_q) begin
            mem_data <= fifo_data;
            mem_addr <= {wr_bank, wr_idx_map};
            wr_cnt   <= wr_cnt + ONE;
         end
         if (state == SWAP) begin
            wr_bank <= ~wr_bank;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: behavioural FIFO, write scoreboard, vector table and corner-case sequences.
module tb_fft_frame_loader;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [3:0] data;
      logic [4:0] nat;
      logic [4:0] rev;
   } vec_t;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        EN = 1'b0;
   logic        frame_ack = 1'b0;
   logic [31:0] fifo_data;
   logic        fifo_empty;
   logic        fifo_rd, mem_we, frame_ready, frame_bank;
   logic [4:0]  mem_addr;
   logic [31:0] mem_data;

   logic [31:0] fq[$];
   wr_t         exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          wr_total = 0;
   logic        m_bank;
   logic [3:0]  m_idx;
   logic        rd_seen;
   logic        cap_en = 1'b0;
   logic [4:0]  cap_addr[16];
   vec_t        tbl[6];

   fft_frame_loader dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .EN          (EN),
      .fifo_data   (fifo_data),
      .fifo_empty  (fifo_empty),
      .fifo_rd     (fifo_rd),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .frame_ready (frame_ready),
      .frame_bank  (frame_bank),
      .frame_ack   (frame_ack)
   );

   always #5 Clk = ~Clk;

   function automatic logic [3:0] tb_map(input logic [3:0] i);
`ifdef BITREV_EN
      return {i[0], i[1], i[2], i[3]};
`else
      return i;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_msg(input string name, input string why);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: %s (t=%0t)", name, why, $time);
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic samp;
      @(negedge Clk);
      #1;
   endtask

   // Each pushed sample predicts its own write: frames fill bank 0, bank 1, bank 0 ...
   task automatic push(input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         wr_t e;
         e.data = base + 32'(k);
         e.addr = {m_bank, tb_map(m_idx)};
         fq.push_back(e.data);
         exp_q.push_back(e);
         m_idx = m_idx + 4'd1;
         if (m_idx == 4'd0) m_bank = ~m_bank;
      end
   endtask

   task automatic do_reset(input int n);
      Rst = 1'b1;
      EN = 1'b0;
      frame_ack = 1'b0;
      fq.delete();
      exp_q.delete();
      m_bank = 1'b0;
      m_idx = 4'd0;
      repeat (n) tick;
      Rst = 1'b0;
   endtask

   task automatic wait_writes(input int target, input int budget);
      int i = 0;
      while (wr_total < target && i < budget) begin
         samp;
         i++;
      end
      if (wr_total < target) fail_msg("wait_writes", $sformatf("timeout with %0d writes, wanted %0d", wr_total, target));
   endtask

   task automatic wait_ready(input int budget);
      int i = 0;
      while (!frame_ready && i < budget) begin
         samp;
         i++;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_fifo_rd"}, 32'(fifo_rd), 0);
      check({tag, "_mem_we"}, 32'(mem_we), 0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 0);
      check({tag, "_mem_data"}, mem_data, 0);
      check({tag, "_frame_ready"}, 32'(frame_ready), 0);
      check({tag, "_frame_bank"}, 32'(frame_bank), 0);
   endtask

   // Behavioural FIFO: RD seen mid-cycle pops at the edge; dataOut is valid the following cycle.
   initial begin
      fifo_empty = 1'b1;
      fifo_data = '0;
      forever begin
         @(negedge Clk);
         rd_seen = fifo_rd;
         @(posedge Clk);
         #2;
         if (rd_seen && fq.size() > 0) fifo_data = fq.pop_front();
         fifo_empty = (fq.size() == 0);
      end
   end

   // Scoreboard consumer: every memory write must match the oldest predicted write.
   initial begin
      wr_t e;
      forever begin
         @(negedge Clk);
         if (!Rst && mem_we) begin
            wr_total++;
            if (cap_en) cap_addr[mem_data[3:0]] = mem_addr;
            if (exp_q.size() == 0) begin
               fail_msg("unexpected_write", $sformatf("addr 0x%0h data 0x%0h", mem_addr, mem_data));
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(mem_addr), 32'(e.addr));
               check("wr_data", mem_data, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w0, c, rd_n, first_rd, last_rd, last_we, fr_c, dips;

      tbl[0] = '{4'h0, 5'h00, 5'h00};
      tbl[1] = '{4'h1, 5'h01, 5'h08};
      tbl[2] = '{4'h3, 5'h03, 5'h0C};
      tbl[3] = '{4'h6, 5'h06, 5'h06};
      tbl[4] = '{4'hA, 5'h0A, 5'h05};
      tbl[5] = '{4'hF, 5'h0F, 5'h0F};

      do_reset(2);
      samp;
      check_idle_outputs("reset");

      // Ack with nothing ready must not move frame_bank.
      tick; frame_ack = 1'b1;
      tick; frame_ack = 1'b0;
      samp;
      check("ack_ignored_ready", 32'(frame_ready), 0);
      check("ack_ignored_bank", 32'(frame_bank), 0);

      // One full frame of 0x0..0xF at full rate.
      push(16, 32'h0);
      cap_en = 1'b1;
      tick; EN = 1'b1;
      w0 = wr_total;
      rd_n = 0; first_rd = -1; last_rd = -1; last_we = -1; fr_c = -1;
      for (c = 1; c <= 40; c++) begin
         samp;
         if (fifo_rd) begin
            rd_n++;
            last_rd = c;
            if (first_rd < 0) first_rd = c;
         end
         if (mem_we) last_we = c;
         if (frame_ready && fr_c < 0) fr_c = c;
      end
      cap_en = 1'b0;
      check("t1_read_count", rd_n, 16);
      check("t1_read_span", last_rd - first_rd, 15);
      check("t1_write_count", wr_total - w0, 16);
      check("t1_ready_delay", fr_c - last_we, 2);
      check("t1_frame_ready", 32'(frame_ready), 1);
      check("t1_frame_bank", 32'(frame_bank), 0);
      check("t1_sb_empty", exp_q.size(), 0);
      for (int i = 0; i < 6; i++) begin
`ifdef BITREV_EN
         check($sformatf("tbl_addr_d%0h", tbl[i].data), 32'(cap_addr[tbl[i].data]), 32'(tbl[i].rev));
`else
         check($sformatf("tbl_addr_d%0h", tbl[i].data), 32'(cap_addr[tbl[i].data]), 32'(tbl[i].nat));
`endif
      end

      // Both banks full: loader stalls with samples still queued, ack releases bank 0.
      do_reset(2);
      w0 = wr_total;
      push(34, 32'h100);
      tick; EN = 1'b1;
      wait_writes(w0 + 32, 200);
      rd_n = 0;
      repeat (10) begin
         samp;
         if (fifo_rd) rd_n++;
      end
      check("full_stall_reads", rd_n, 0);
      check("full_writes", wr_total - w0, 32);
      check("full_ready", 32'(frame_ready), 1);
      check("full_bank", 32'(frame_bank), 0);
      tick; frame_ack = 1'b1;
      tick; frame_ack = 1'b0;
      samp;
      check("ack_bank", 32'(frame_bank), 1);
      check("ack_ready", 32'(frame_ready), 1);
      wait_writes(w0 + 34, 50);
      repeat (4) samp;
      check("resume_writes", wr_total - w0, 34);
      check("resume_sb_empty", exp_q.size(), 0);

      // FIFO runs dry after six samples; the frame resumes at index 6.
      do_reset(2);
      w0 = wr_total;
      push(6, 32'h200);
      tick; EN = 1'b1;
      wait_writes(w0 + 6, 50);
      rd_n = 0;
      repeat (7) begin
         samp;
         if (fifo_rd) rd_n++;
      end
      check("empty_pause_reads", rd_n, 0);
      tick;
      push(10, 32'h206);
      wait_writes(w0 + 16, 100);
      wait_ready(10);
      repeat (4) samp;
      check("empty_frame_ready", 32'(frame_ready), 1);
      check("empty_frame_writes", wr_total - w0, 16);
      check("empty_sb_empty", exp_q.size(), 0);

      // Reset after nine samples discards the partial frame.
      do_reset(2);
      w0 = wr_total;
      push(16, 32'h300);
      tick; EN = 1'b1;
      wait_writes(w0 + 9, 50);
      do_reset(1);
      samp;
      check_idle_outputs("midrst");
      w0 = wr_total;
      push(16, 32'h400);
      tick; EN = 1'b1;
      wait_writes(w0 + 16, 100);
      wait_ready(10);
      check("midrst_ready", 32'(frame_ready), 1);
      check("midrst_bank", 32'(frame_bank), 0);
      check("midrst_sb_empty", exp_q.size(), 0);

      // Ack of bank 0 lands in the same cycle bank 1 is marked full.
      do_reset(2);
      w0 = wr_total;
      push(32, 32'h500);
      tick; EN = 1'b1;
      wait_writes(w0 + 32, 200);
      tick; frame_ack = 1'b1;
      samp;
      check("coinc_ready_at_swap", 32'(frame_ready), 1);
      tick; frame_ack = 1'b0;
      samp;
      check("coinc_ready", 32'(frame_ready), 1);
      check("coinc_bank", 32'(frame_bank), 1);
      dips = 0;
      repeat (4) begin
         samp;
         if (!frame_ready || !frame_bank) dips++;
      end
      check("coinc_hold", dips, 0);
      check("coinc_sb_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
